// File: rtl/led_pattern_shifter_pkg.sv
// Shared encodings for the LED pattern shifter: step modes and bounce direction.
package led_pattern_shifter_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/led_pattern_shifter_if.sv
// Control/status bundle of the LED pattern shifter; master drives controls, slave returns the pattern.
interface led_pattern_shifter_if
  import led_pattern_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 32
);
  logic             en;
  mode_t            mode;
  logic [CNT_W-1:0] period;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] leds;
  logic             tick;
  logic             dir;

  modport master (
    output en, mode, period, load, load_value,
    input  leds, tick, dir
  );

  modport slave (
    input  en, mode, period, load, load_value,
    output leds, tick, dir
  );
endinterface

// File: rtl/led_pattern_shifter_tick_gen.sv
// Prescaler: counts enabled cycles and flags a step once count reaches period.
module tick_gen #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             step
);
  logic [CNT_W-1:0] count;

  // >= rather than == so a period lowered below the running count steps at once
  assign step = en && !clr && (count >= period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || step) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/led_pattern_shifter.sv
// LED pattern shifter: rotates or bounces a pattern once per prescaled step, with load and hold.
module led_pattern_shifter
  import led_pattern_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic [31:0] INIT  = 32'h1F,
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  led_pattern_shifter_if.slave bus
);
  logic [WIDTH-1:0] leds_q;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  dir_t             dir_q;
  logic             tick_q;
  logic             step;

  tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .clr    (bus.load),
    .period (bus.period),
    .step   (step)
  );

  assign rol = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
  assign ror = {leds_q[0], leds_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_q <= INIT[WIDTH-1:0];
      dir_q  <= DIR_LEFT;
      tick_q <= 1'b0;
    end else begin
      // step is already suppressed by load, so no tick on a load cycle
      tick_q <= step;
      if (bus.load) begin
        leds_q <= bus.load_value;
        dir_q  <= DIR_LEFT;
      end else if (step) begin
        case (bus.mode)
          ROT_L: leds_q <= rol;
          ROT_R: leds_q <= ror;
          BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (leds_q[WIDTH-1]) begin
                dir_q  <= DIR_RIGHT;
                leds_q <= ror;
              end else begin
                leds_q <= rol;
              end
            end else begin
              if (leds_q[0]) begin
                dir_q  <= DIR_LEFT;
                leds_q <= rol;
              end else begin
                leds_q <= ror;
              end
            end
          end
          default: leds_q <= leds_q;
        endcase
      end
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;
  assign bus.dir  = dir_q;
endmodule

// File: tb/tb_led_pattern_shifter.sv
// Self-checking bench for led_pattern_shifter: vector table, directed corner cases, random vs model.
module tb_led_pattern_shifter;
  import led_pattern_shifter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pattern_shifter_if #(.WIDTH(8), .CNT_W(32)) bus ();
  led_pattern_shifter_if #(.WIDTH(4), .CNT_W(32)) bus4 ();

  led_pattern_shifter #(.WIDTH(8), .INIT(32'h1F), .CNT_W(32)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  led_pattern_shifter #(.WIDTH(4), .INIT(32'h1F), .CNT_W(32)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: pattern as a number, rotations as multiply/divide by two
  int unsigned     m_leds;
  bit              m_dir;
  bit              m_tick;
  longint unsigned m_cnt;

  function automatic int unsigned rot_l8(input int unsigned x);
    return ((x * 2) + (x / 128)) % 256;
  endfunction

  function automatic int unsigned rot_r8(input int unsigned x);
    return (x / 2) + ((x % 2) * 128);
  endfunction

  task automatic model_reset();
    m_leds = 32'h1F; m_dir = 1'b0; m_tick = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (bus.load) begin
      m_leds = bus.load_value; m_cnt = 0; m_dir = 1'b0; m_tick = 1'b0;
    end else if (!bus.en) begin
      m_tick = 1'b0;
    end else if (m_cnt >= bus.period) begin
      m_cnt = 0; m_tick = 1'b1;
      case (int'(bus.mode))
        0: m_leds = rot_l8(m_leds);
        1: m_leds = rot_r8(m_leds);
        2: begin
          if (!m_dir && m_leds >= 128) begin m_dir = 1'b1; m_leds = rot_r8(m_leds); end
          else if (!m_dir)             m_leds = rot_l8(m_leds);
          else if (m_leds % 2 == 1)    begin m_dir = 1'b0; m_leds = rot_l8(m_leds); end
          else                         m_leds = rot_r8(m_leds);
        end
        default: ;
      endcase
    end else begin
      m_cnt++; m_tick = 1'b0;
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_leds"}, bus.leds, m_leds);
    chk({tag, "_tick"}, bus.tick, m_tick);
    chk({tag, "_dir"},  bus.dir,  m_dir);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step_clk();
    step_clk();
    rst = 1'b0;
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!bus.tick && n < 20);
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    int unsigned period;
    logic        load;
    logic [7:0]  lv;
    logic [7:0]  e_leds;
    logic        e_tick;
    logic        e_dir;
  } vec_t;

  vec_t tbl[15];
  int   n;
  int unsigned exp_v;

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'h1F, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'h3E, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'h3E, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'h7C, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'h7C, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'hF8, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'hF8, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1, 1'b0, 8'h00, 8'hF1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 1, 1'b0, 8'h00, 8'hF1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 1, 1'b0, 8'h00, 8'hF1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 0, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd1, 0, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'd1, 0, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'd1, 0, 1'b0, 8'h00, 8'h60, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 0, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0};

    bus.en = 1'b0; bus.mode = ROT_L; bus.period = '0; bus.load = 1'b0; bus.load_value = '0;
    bus4.en = 1'b1; bus4.mode = ROT_L; bus4.period = 32'd1; bus4.load = 1'b0; bus4.load_value = '0;
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_leds", bus.leds, 8'h1F);
    step_clk();
    chk("rst_leds", bus.leds, 8'h1F);
    chk("rst_tick", bus.tick, 0);
    chk("rst_dir",  bus.dir,  0);
    chk("rst_w4_leds", bus4.leds, 4'hF);
    step_clk();
    rst = 1'b0;

    // Vector table: rotate-left run, hold, load, rotate-right, enable gap
    for (int i = 0; i < 15; i++) begin
      bus.en = tbl[i].en; bus.mode = mode_t'(tbl[i].mode); bus.period = tbl[i].period;
      bus.load = tbl[i].load; bus.load_value = tbl[i].lv;
      step_clk();
      chk($sformatf("vec%0d_leds", i), bus.leds, tbl[i].e_leds);
      chk($sformatf("vec%0d_tick", i), bus.tick, tbl[i].e_tick);
      chk($sformatf("vec%0d_dir", i),  bus.dir,  tbl[i].e_dir);
      if (i < 10) begin
        chk($sformatf("w4_vec%0d_leds", i), bus4.leds, 4'hF);
        chk($sformatf("w4_vec%0d_tick", i), bus4.tick, tbl[i].e_tick);
      end
    end

    // Bounce sweep from a single lit LED with period 0
    bus.load = 1'b1; bus.load_value = 8'h01; bus.mode = BOUNCE; bus.period = '0; bus.en = 1'b1;
    step_clk();
    chk("bnc_load_leds", bus.leds, 8'h01);
    chk("bnc_load_tick", bus.tick, 0);
    bus.load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step_clk();
      exp_v = 1 << k;
      chk($sformatf("bnc_up%0d_leds", k), bus.leds, exp_v);
      chk($sformatf("bnc_up%0d_tick", k), bus.tick, 1);
      chk($sformatf("bnc_up%0d_dir", k),  bus.dir,  0);
    end
    for (int k = 6; k >= 0; k--) begin
      step_clk();
      exp_v = 1 << k;
      chk($sformatf("bnc_dn%0d_leds", k), bus.leds, exp_v);
      chk($sformatf("bnc_dn%0d_dir", k),  bus.dir,  1);
    end
    step_clk();
    chk("bnc_turn_leds", bus.leds, 8'h02);
    chk("bnc_turn_dir",  bus.dir,  0);

    // All-ones bounce toggles direction every step
    bus.load = 1'b1; bus.load_value = 8'hFF;
    step_clk();
    bus.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_clk();
      chk($sformatf("ones%0d_leds", k), bus.leds, 8'hFF);
      chk($sformatf("ones%0d_dir", k),  bus.dir,  (k % 2 == 0) ? 1 : 0);
    end

    // Asynchronous reset between edges while bouncing rightwards
    bus.load = 1'b1; bus.load_value = 8'h80;
    step_clk();
    bus.load = 1'b0;
    step_clk();
    chk("prerst_leds", bus.leds, 8'h40);
    chk("prerst_dir",  bus.dir,  1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_leds", bus.leds, 8'h1F);
    chk("arst_dir",  bus.dir,  0);
    chk("arst_tick", bus.tick, 0);
    step_clk();
    rst = 1'b0;

    // Lowering period below the running count forces an immediate step
    bus.mode = ROT_L; bus.period = 32'd9; bus.en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step_clk();
      chk($sformatf("plow_wait%0d_tick", k), bus.tick, 0);
    end
    bus.period = 32'd2;
    step_clk();
    chk("plow_step_tick", bus.tick, 1);
    chk("plow_step_leds", bus.leds, 8'h3E);
    step_clk(); chk("plow_a_tick", bus.tick, 0);
    step_clk(); chk("plow_b_tick", bus.tick, 0);
    step_clk(); chk("plow_c_tick", bus.tick, 1);
    chk("plow_c_leds", bus.leds, 8'h7C);

    // Enable gap mid-interval freezes everything and delays the step by the gap
    do_reset();
    bus.mode = ROT_L; bus.period = 32'd3; bus.en = 1'b1;
    step_clk(); step_clk();
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step_clk();
      chk($sformatf("engap%0d_leds", k), bus.leds, 8'h1F);
      chk($sformatf("engap%0d_tick", k), bus.tick, 0);
    end
    bus.en = 1'b1;
    cycles_to_tick(n);
    chk("engap_resume_cycles", n, 2);
    chk("engap_resume_leds", bus.leds, 8'h3E);

    // Load coinciding with a due step wins; interval restarts from zero
    do_reset();
    bus.mode = ROT_L; bus.period = 32'd2; bus.en = 1'b1;
    step_clk(); step_clk();
    bus.load = 1'b1; bus.load_value = 8'hA5;
    step_clk();
    chk("ldstep_leds", bus.leds, 8'hA5);
    chk("ldstep_tick", bus.tick, 0);
    bus.load = 1'b0;
    cycles_to_tick(n);
    chk("ldstep_next_cycles", n, 3);
    chk("ldstep_next_leds", bus.leds, 8'h4B);

    // Random stimulus against the reference model
    do_reset();
    bus.mode = ROT_L; bus.period = 32'd1; bus.en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      bus.load = ($urandom_range(0, 19) == 0);
      bus.load_value = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.mode = mode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.period = $urandom_range(0, 5);
      step_clk();
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
